// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes engine.
// A 128-bit state is accepted in IDLE, rewritten LANES bytes per cycle through
// a bank of inverse S-box lanes during RUN, then presented in DONE until taken.

// One inverse S-box lane: pure 256-entry lookup table.
module inv_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout = INV_SBOX[din];
endmodule

module inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data_out,
    output logic         o_busy
);
    localparam int BEATS = 16 / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [BW-1:0]           beat;
    logic [127:0]            work;
    logic [127:0]            work_nxt;
    logic [127:0]            out_reg;
    logic [LANES-1:0][7:0]   lane_in;
    logic [LANES-1:0][7:0]   lane_out;
    int                      base;

    // Bit offset of the byte group handled in the current beat.
    assign base = int'(beat) * LANES * 8;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_lane u_lane (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    // Route the current beat's bytes into the lanes.
    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) lane_in[l] = work[base + l*8 +: 8];
    end

    // Splice the substituted bytes back; everything else passes through.
    always_comb begin
        work_nxt = work;
        for (int l = 0; l < LANES; l++) work_nxt[base + l*8 +: 8] = lane_out[l];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            work    <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    work  <= i_data_in;
                    beat  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    work <= work_nxt;
                    if (beat == BW'(BEATS - 1)) begin
                        out_reg <= work_nxt;
                        beat    <= '0;
                        state   <= DONE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_valid    = (state == DONE);
    assign o_busy     = (state == RUN) || (state == DONE);
    assign o_data_out = out_reg;
endmodule

// File: tb/tb_inv_sub_bytes.sv
// Bench for inv_sub_bytes: five instances (LANES 1,2,4,8,16) share one input
// stream; a cycle-level transaction model built on a GF(2^8)-derived S-box
// is compared against every output each cycle, plus literal known answers.
module tb_inv_sub_bytes;
    logic         clk = 0, rst_n = 0, valid = 0, ready = 0;
    logic [127:0] din = '0;
    logic [4:0]   rdy, vld, bsy;
    logic [127:0] dout [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes #(.LANES(1 << g)) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_valid    (valid),
            .o_ready    (rdy[g]),
            .i_data_in  (din),
            .o_valid    (vld[g]),
            .i_ready    (ready),
            .o_data_out (dout[g]),
            .o_busy     (bsy[g])
        );
    end

    // Reference tables derived from field inversion + affine map.
    logic [7:0] sbox [256];
    logic [7:0] isbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = isbox[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox[s[8*k +: 8]];
        return r;
    endfunction

    // Transaction model: accept in idle, result after 16/LANES cycles, held until taken.
    logic         m_busy [5], m_vld [5];
    int           m_cnt  [5];
    logic [127:0] m_pend [5], m_out [5];

    always @(posedge clk or negedge rst_n) begin
        for (int j = 0; j < 5; j++) begin
            if (!rst_n) begin
                m_busy[j] <= 0; m_vld[j] <= 0; m_cnt[j] <= 0; m_out[j] <= '0; m_pend[j] <= '0;
            end else if (m_vld[j]) begin
                if (ready) m_vld[j] <= 0;
            end else if (m_busy[j]) begin
                if (m_cnt[j] + 1 == (16 >> j)) begin
                    m_busy[j] <= 0; m_vld[j] <= 1; m_out[j] <= m_pend[j];
                end else m_cnt[j] <= m_cnt[j] + 1;
            end else if (valid) begin
                m_busy[j] <= 1; m_cnt[j] <= 0; m_pend[j] <= inv_state(din);
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, compare every instance to the model, then step off the edge.
    task automatic tick();
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("o_ready[L%0d]", 1 << j), 128'(rdy[j]), 128'(!(m_busy[j] || m_vld[j])));
            chk($sformatf("o_valid[L%0d]", 1 << j), 128'(vld[j]), 128'(m_vld[j]));
            chk($sformatf("o_busy[L%0d]",  1 << j), 128'(bsy[j]), 128'(m_busy[j] || m_vld[j]));
            chk($sformatf("o_data[L%0d]",  1 << j), dout[j], m_out[j]);
        end
        #1;
    endtask

    // Feed one state, check per-instance latency and literal result; optionally take the results.
    task automatic run_txn(input logic [127:0] data, input logic [127:0] exp, input bit take);
        int n = 0;
        int lat [5];
        while (rdy != 5'h1f && n < 100) begin tick(); n++; end
        if (n == 100) begin errors++; checks++; $display("FAIL ready_timeout actual=%b required=11111", rdy); end
        valid = 1; din = data;
        tick();
        valid = 0;
        for (int j = 0; j < 5; j++) lat[j] = 0;
        for (int k = 2; k < 40 && vld != 5'h1f; k++) begin
            tick();
            for (int j = 0; j < 5; j++) if (vld[j] && lat[j] == 0) lat[j] = k - 1;
        end
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("latency[L%0d]", 1 << j), 128'(lat[j]), 128'(16 >> j));
            chk($sformatf("result[L%0d]",  1 << j), dout[j], exp);
        end
        if (take) begin ready = 1; tick(); ready = 0; end
    endtask

    initial begin
        logic [127:0] held, orig;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 0, s;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x] = s;
            isbox[s] = 8'(x);
        end
        chk("model_sbox_53", 128'(sbox[8'h53]), 128'h ed);
        chk("model_isbox_63", 128'(isbox[8'h63]), 128'h00);
        chk("model_isbox_7c", 128'(isbox[8'h7c]), 128'h01);
        chk("model_isbox_d4", 128'(isbox[8'hd4]), 128'h19);

        // Reset values
        tick(); tick();
        chk("rst_ready", 128'(rdy), 128'h1f);
        chk("rst_valid", 128'(vld), 128'h0);
        chk("rst_busy",  128'(bsy), 128'h0);
        for (int j = 0; j < 5; j++) chk($sformatf("rst_data[L%0d]", 1 << j), dout[j], '0);
        rst_n = 1;
        tick();

        // Known answer and edge bytes
        run_txn(128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1);
        run_txn({16{8'h63}}, {16{8'h00}}, 1);
        run_txn({16{8'h16}}, {16{8'hff}}, 1);
        run_txn({16{8'h00}}, {16{8'h52}}, 1);
        run_txn({16{8'hff}}, {16{8'h7d}}, 1);

        // Backpressure: results held in DONE while new input is offered
        run_txn(128'h000102030405060708090a0b0c0d0e0f, 128'h5209_6ad5_3036_a538_bf40_a39e_81f3_d7fb, 0);
        held = dout[2];
        for (int i = 0; i < 10; i++) begin
            valid = 1; din = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_ready", 128'(rdy), 128'h00);
            chk("bp_valid", 128'(vld), 128'h1f);
            chk("bp_hold",  dout[2], held);
        end
        din = {16{8'h63}}; ready = 1;
        tick();
        chk("bp_one_idle", 128'(rdy), 128'h1f);
        ready = 0;
        tick();
        chk("bp_accept", 128'(bsy), 128'h1f);
        valid = 0;
        for (int k = 0; k < 40 && vld != 5'h1f; k++) tick();
        for (int j = 0; j < 5; j++) chk($sformatf("bp_result[L%0d]", 1 << j), dout[j], '0);
        ready = 1; tick(); ready = 0;

        // Reset in the middle of RUN (beat 1 of the LANES=4 instance)
        valid = 1; din = {16{8'h11}};
        tick();
        valid = 0;
        tick();
        rst_n = 0;
        tick(); tick();
        chk("midrst_valid", 128'(vld), 128'h0);
        for (int j = 0; j < 5; j++) chk($sformatf("midrst_data[L%0d]", 1 << j), dout[j], '0);
        rst_n = 1;
        tick();
        run_txn({16{8'h7c}}, {16{8'h01}}, 1);

        // Round trip through the forward substitution
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_txn(fwd_state(orig), orig, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
